// File: rtl/gt_link_pkg.sv
// rtl/gt_link_pkg.sv - shared state encoding and counter sizing for the GT link sequencer
package gt_link_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_QPLL_WAIT  = 4'd1,
        ST_TX_RST     = 4'd2,
        ST_TX_WAIT    = 4'd3,
        ST_RX_RST     = 4'd4,
        ST_RX_WAIT    = 4'd5,
        ST_ALIGN_WAIT = 4'd6,
        ST_LINK_UP    = 4'd7,
        ST_RETRY      = 4'd8,
        ST_FAIL       = 4'd9
    } gt_state_e;

    // Bits needed to hold values 0..n inclusive, never less than one.
    function automatic int cnt_width(input int n);
        cnt_width = (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gt_sync_bit.sv
// rtl/gt_sync_bit.sv - two-flop synchronizer for a single asynchronous status bit
module gt_sync_bit (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gt_link_ctrl.sv
// rtl/gt_link_ctrl.sv - GT channel bring-up/retrain sequencer driving TX/RX soft resets
// Outputs are decoded from the next state so they switch on the same edge as the state register.
module gt_link_ctrl
    import gt_link_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int TIMEOUT_CYC      = 1_000_000,
    parameter int ALIGN_STABLE_CYC = 1024,
    parameter int MAX_RETRY        = 8
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst_n,
    input  logic       i_enable,
    input  logic       i_force_retrain,
    input  logic       i_qplllock,
    input  logic       i_tx_done,
    input  logic       i_rx_done,
    input  logic       i_rx_aligned,
    output logic       o_tx_reset,
    output logic       o_rx_reset,
    output logic       o_link_up,
    output logic       o_fail,
    output logic [3:0] o_retry_cnt,
    output logic [3:0] o_state
);

    localparam int TMR_MAX = (TIMEOUT_CYC > RST_PULSE_CYC) ? TIMEOUT_CYC : RST_PULSE_CYC;
    localparam int TW      = cnt_width(TMR_MAX);
    localparam int AW      = cnt_width(ALIGN_STABLE_CYC);

    localparam logic [TW-1:0] TMR_SAT    = {TW{1'b1}};
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] RST_LAST   = TW'(RST_PULSE_CYC - 1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_STABLE_CYC - 1);
    localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRY);

    logic lock_s, txd_s, rxd_s, align_s;

    gt_sync_bit u_sync_lock  (.clk_i(i_sys_clk), .rst_ni(i_sys_rst_n), .d_i(i_qplllock),   .q_o(lock_s));
    gt_sync_bit u_sync_txd   (.clk_i(i_sys_clk), .rst_ni(i_sys_rst_n), .d_i(i_tx_done),    .q_o(txd_s));
    gt_sync_bit u_sync_rxd   (.clk_i(i_sys_clk), .rst_ni(i_sys_rst_n), .d_i(i_rx_done),    .q_o(rxd_s));
    gt_sync_bit u_sync_align (.clk_i(i_sys_clk), .rst_ni(i_sys_rst_n), .d_i(i_rx_aligned), .q_o(align_s));

    gt_state_e       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   align_q, align_d;
    logic [3:0]      retry_q, retry_d;
    logic            tx_rst_q, tx_rst_d;
    logic            rx_rst_q, rx_rst_d;
    logic            link_up_q, link_up_d;
    logic            fail_q, fail_d;
    logic            wait_st;

    always_comb begin
        state_d = state_q;
        align_d = '0;
        wait_st = state_q inside {ST_QPLL_WAIT, ST_TX_WAIT, ST_RX_WAIT, ST_ALIGN_WAIT};

        case (state_q)
            ST_IDLE:       if (i_enable) state_d = ST_QPLL_WAIT;
            ST_QPLL_WAIT:  if (lock_s) state_d = ST_TX_RST;
            ST_TX_RST:     if (timer_q == RST_LAST) state_d = ST_TX_WAIT;
            ST_TX_WAIT:    if (txd_s) state_d = ST_RX_RST;
            ST_RX_RST:     if (timer_q == RST_LAST) state_d = ST_RX_WAIT;
            ST_RX_WAIT:    if (rxd_s) state_d = ST_ALIGN_WAIT;
            ST_ALIGN_WAIT: begin
                if (align_s) begin
                    if (align_q == ALIGN_LAST) state_d = ST_LINK_UP;
                    else                       align_d = align_q + AW'(1);
                end
            end
            ST_LINK_UP:    if (!align_s || !lock_s || !txd_s) state_d = ST_RETRY;
            ST_RETRY:      state_d = (retry_q >= RETRY_LIM) ? ST_FAIL : ST_QPLL_WAIT;
            ST_FAIL:       state_d = ST_FAIL;
            default:       state_d = ST_IDLE;
        endcase

        // Overrides applied lowest priority first so the last one wins.
        if (wait_st && (timer_q == TO_LAST)) state_d = ST_RETRY;
        if (i_force_retrain && !(state_q inside {ST_IDLE, ST_RETRY, ST_FAIL})) state_d = ST_RETRY;
        if (!i_enable) state_d = ST_IDLE;

        if (state_d != ST_ALIGN_WAIT) align_d = '0;

        if (state_d != state_q)    timer_d = '0;
        else if (timer_q == TMR_SAT) timer_d = timer_q;
        else                       timer_d = timer_q + TW'(1);

        if (state_d == ST_RETRY)
            retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        else if (state_d inside {ST_IDLE, ST_LINK_UP})
            retry_d = '0;
        else
            retry_d = retry_q;

        tx_rst_d  = !(state_d inside {ST_TX_WAIT, ST_RX_RST, ST_RX_WAIT, ST_ALIGN_WAIT, ST_LINK_UP});
        rx_rst_d  = !(state_d inside {ST_RX_WAIT, ST_ALIGN_WAIT, ST_LINK_UP});
        link_up_d = (state_d == ST_LINK_UP);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            align_q   <= '0;
            retry_q   <= '0;
            tx_rst_q  <= 1'b1;
            rx_rst_q  <= 1'b1;
            link_up_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            align_q   <= align_d;
            retry_q   <= retry_d;
            tx_rst_q  <= tx_rst_d;
            rx_rst_q  <= rx_rst_d;
            link_up_q <= link_up_d;
            fail_q    <= fail_d;
        end
    end

    assign o_tx_reset  = tx_rst_q;
    assign o_rx_reset  = rx_rst_q;
    assign o_link_up   = link_up_q;
    assign o_fail      = fail_q;
    assign o_retry_cnt = retry_q;
    assign o_state     = state_q;

endmodule
